// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions: transfer/response codes, splitter states and
// the read-data value returned when no slave owns the data phase.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [31:0] AHB_RD_DEFAULT = 32'hBADDBEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SLAVE,
        ST_ERR1,
        ST_ERR2
    } split_state_t;

endpackage

// File: rtl/ahbl_slot_decoder.sv
// Combinational slot decoder: maps a 4-bit slot field onto one of NS slave
// slots, giving a one-hot select, the matching index and a hit flag.
module ahbl_slot_decoder #(
    parameter int              NS       = 5,
    parameter logic [4*NS-1:0] SLOT_IDS = {4'h4, 4'h3, 4'h2, 4'h1, 4'h0},
    localparam int             IW       = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic [3:0]    slot,
    output logic [NS-1:0] onehot,
    output logic [IW-1:0] idx,
    output logic          hit
);

    always_comb begin
        idx    = '0;
        hit    = 1'b0;
        onehot = '0;
        // Scan from the top down so the lowest matching index is the one kept.
        for (int i = NS - 1; i >= 0; i--) begin
            if (slot == SLOT_IDS[4*i +: 4]) begin
                idx = IW'(i);
                hit = 1'b1;
            end
        end
        if (hit) begin
            onehot = NS'(1) << idx;
        end
    end

endmodule

// File: rtl/ahbl_splitter_n.sv
// AHB-Lite data-phase splitter for NS slaves with a built-in default slave
// (two-cycle ERROR for unmapped slots) and a per-transfer wait-state watchdog.
module ahbl_splitter_n
    import ahbl_pkg::*;
#(
    parameter int              NS         = 5,
    parameter logic [4*NS-1:0] SLOT_IDS   = {4'h4, 4'h3, 4'h2, 4'h1, 4'h0},
    parameter int              TIMEOUT    = 255,
    parameter logic [31:0]     RD_DEFAULT = AHB_RD_DEFAULT
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    output logic             HREADY,
    output logic             HRESP,
    output logic [31:0]      HRDATA,
    output logic [NS-1:0]    S_SEL,
    input  logic [NS*32-1:0] S_HRDATA,
    input  logic [NS-1:0]    S_HREADYOUT,
    input  logic [NS-1:0]    S_HRESP,
    output logic             TO_PULSE
);

    localparam int          IW      = (NS > 1) ? $clog2(NS) : 1;
    localparam bit          WDOG_EN = (TIMEOUT != 0);
    localparam logic [15:0] TO_LIM  = 16'(TIMEOUT - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    split_state_t  state, state_nx;
    logic [IW-1:0] sel_d, sel_nx;
    logic [15:0]   wcnt, wcnt_nx;
    logic          to_q, fire;

    logic [NS-1:0] dec_onehot;
    logic [IW-1:0] dec_idx;
    logic          dec_hit;
    logic          accept;
    logic [31:0]   s_rdata [NS];
    logic          unused_addr;

    assign unused_addr = ^{HADDR[31:28], HADDR[23:0]};

    ahbl_slot_decoder #(
        .NS       (NS),
        .SLOT_IDS (SLOT_IDS)
    ) u_dec (
        .slot   (HADDR[27:24]),
        .onehot (dec_onehot),
        .idx    (dec_idx),
        .hit    (dec_hit)
    );

    // Address phase: select follows the bus combinationally, even in reset.
    assign S_SEL = HSEL ? dec_onehot : '0;

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            s_rdata[i] = S_HRDATA[32*i +: 32];
        end
    end

    // Data phase: response mux driven by the registered state.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = RD_DEFAULT;
        case (state)
            ST_SLAVE: begin
                HREADY = S_HREADYOUT[sel_d];
                HRESP  = S_HRESP[sel_d];
                HRDATA = s_rdata[sel_d];
            end
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = HRESP_ERROR;
            end
            ST_ERR2: begin
                HRESP  = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    assign accept = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

    always_comb begin
        state_nx = state;
        sel_nx   = sel_d;
        wcnt_nx  = wcnt;
        fire     = 1'b0;
        if (accept) begin
            sel_nx   = dec_idx;
            wcnt_nx  = '0;
            state_nx = dec_hit ? ST_SLAVE : ST_ERR1;
        end else if (HREADY) begin
            state_nx = ST_IDLE;
        end else begin
            // HREADY low only occurs while a slave waits or in ERR1.
            case (state)
                ST_ERR1: state_nx = ST_ERR2;
                ST_SLAVE: begin
                    if (WDOG_EN && (wcnt == TO_LIM)) begin
                        state_nx = ST_ERR1;
                        fire     = 1'b1;
                    end else begin
                        wcnt_nx = sat_inc(wcnt);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
            sel_d <= '0;
            wcnt  <= '0;
            to_q  <= 1'b0;
        end else begin
            state <= state_nx;
            sel_d <= sel_nx;
            wcnt  <= wcnt_nx;
            to_q  <= fire;
        end
    end

    // Registered so the pulse lines up with the first forced ERR1 cycle.
    assign TO_PULSE = to_q;

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Directed bench for ahbl_splitter_n: per-cycle vector table plus hand-written
// watchdog sequences, with NS=5 and TIMEOUT=8.
module tb_ahbl_splitter_n;

    localparam logic [31:0] DF = 32'hBADDBEEF;
    localparam logic [31:0] D0 = 32'hC0DE0000;
    localparam logic [31:0] D1 = 32'hC0DE0001;
    localparam logic [31:0] D2 = 32'h12345678;
    localparam logic [31:0] D3 = 32'hC0DE0003;
    localparam logic [31:0] D4 = 32'hC0DE0004;
    localparam logic [1:0]  IDL = 2'b00;
    localparam logic [1:0]  BSY = 2'b01;
    localparam logic [1:0]  NON = 2'b10;
    localparam logic [1:0]  SQ  = 2'b11;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic         HSEL;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HREADY;
    logic         HRESP;
    logic [31:0]  HRDATA;
    logic [4:0]   S_SEL;
    logic [159:0] S_HRDATA;
    logic [4:0]   S_HREADYOUT;
    logic [4:0]   S_HRESP;
    logic         TO_PULSE;

    int errors = 0;
    int checks = 0;

    assign S_HRDATA = {D4, D3, D2, D1, D0};

    always #5 HCLK = ~HCLK;

    ahbl_splitter_n #(
        .NS         (5),
        .SLOT_IDS   (20'h43210),
        .TIMEOUT    (8),
        .RD_DEFAULT (32'hBADDBEEF)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
        .S_SEL       (S_SEL),
        .S_HRDATA    (S_HRDATA),
        .S_HREADYOUT (S_HREADYOUT),
        .S_HRESP     (S_HRESP),
        .TO_PULSE    (TO_PULSE)
    );

    typedef struct {
        logic        chk;
        logic        rst;
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [4:0]  rdy;
        logic [4:0]  resp;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_data;
        logic [4:0]  e_ssel;
        logic        e_to;
    } vec_t;

    vec_t vt [27];

    function automatic vec_t mk(logic c, logic r, logic s, logic [31:0] a, logic [1:0] t,
                                logic [4:0] rd, logic [4:0] rp, logic er, logic ep,
                                logic [31:0] ed, logic [4:0] es, logic et);
        vec_t v;
        v.chk = c; v.rst = r; v.sel = s; v.addr = a; v.trans = t; v.rdy = rd; v.resp = rp;
        v.e_rdy = er; v.e_resp = ep; v.e_data = ed; v.e_ssel = es; v.e_to = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [31:0] a,
                         input logic [1:0] t, input logic [4:0] rd, input logic [4:0] rp);
        HRESET = r; HSEL = s; HADDR = a; HTRANS = t; S_HREADYOUT = rd; S_HRESP = rp;
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string n, input logic er, input logic ep, input logic [31:0] ed,
                       input logic [4:0] es, input logic et);
        @(negedge HCLK);
        chk({n, " hready"}, 32'(HREADY), 32'(er));
        chk({n, " hresp"}, 32'(HRESP), 32'(ep));
        chk({n, " hrdata"}, HRDATA, ed);
        chk({n, " s_sel"}, 32'(S_SEL), 32'(es));
        chk({n, " to_pulse"}, 32'(TO_PULSE), 32'(et));
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        vt[0]  = mk(0, 1, 0, 32'h0, IDL, 5'h1F, 5'h00, 1, 0, DF, 5'b00000, 0);
        vt[1]  = mk(1, 1, 0, 32'h0, IDL, 5'h1F, 5'h00, 1, 0, DF, 5'b00000, 0);
        vt[2]  = mk(1, 1, 1, 32'h0300_0000, IDL, 5'h1F, 5'h00, 1, 0, DF, 5'b01000, 0);
        vt[3]  = mk(1, 0, 1, 32'h0200_0000, NON, 5'h1F, 5'h00, 1, 0, DF, 5'b00100, 0);
        vt[4]  = mk(1, 0, 0, 32'h0, IDL, 5'h1F, 5'h00, 1, 0, D2, 5'b00000, 0);
        vt[5]  = mk(1, 0, 0, 32'h0, IDL, 5'h1F, 5'h00, 1, 0, DF, 5'b00000, 0);
        vt[6]  = mk(1, 0, 1, 32'h4F00_0000, NON, 5'h1F, 5'h00, 1, 0, DF, 5'b00000, 0);
        vt[7]  = mk(1, 0, 0, 32'h0, IDL, 5'h1F, 5'h00, 0, 1, DF, 5'b00000, 0);
        vt[8]  = mk(1, 0, 0, 32'h0, IDL, 5'h1F, 5'h00, 1, 1, DF, 5'b00000, 0);
        vt[9]  = mk(1, 0, 0, 32'h0, IDL, 5'h1F, 5'h00, 1, 0, DF, 5'b00000, 0);
        vt[10] = mk(1, 0, 1, 32'h0100_0000, NON, 5'h1F, 5'h00, 1, 0, DF, 5'b00010, 0);
        vt[11] = mk(1, 0, 1, 32'h0400_0000, NON, 5'b11101, 5'h00, 0, 0, D1, 5'b10000, 0);
        vt[12] = mk(1, 0, 1, 32'h0400_0000, NON, 5'h1F, 5'h00, 1, 0, D1, 5'b10000, 0);
        vt[13] = mk(1, 0, 0, 32'h0, IDL, 5'h1F, 5'h00, 1, 0, D4, 5'b00000, 0);
        vt[14] = mk(1, 0, 0, 32'h0, IDL, 5'h1F, 5'h00, 1, 0, DF, 5'b00000, 0);
        vt[15] = mk(1, 0, 1, 32'h0000_0000, SQ, 5'h1F, 5'h00, 1, 0, DF, 5'b00001, 0);
        vt[16] = mk(1, 0, 0, 32'h0, IDL, 5'h1F, 5'b00001, 1, 1, D0, 5'b00000, 0);
        vt[17] = mk(1, 0, 0, 32'h0, IDL, 5'h1F, 5'h00, 1, 0, DF, 5'b00000, 0);
        vt[18] = mk(1, 0, 1, 32'h0300_0000, BSY, 5'h1F, 5'h00, 1, 0, DF, 5'b01000, 0);
        vt[19] = mk(1, 0, 0, 32'h0, IDL, 5'h1F, 5'h00, 1, 0, DF, 5'b00000, 0);
        vt[20] = mk(1, 0, 1, 32'h0900_0000, NON, 5'h1F, 5'h00, 1, 0, DF, 5'b00000, 0);
        vt[21] = mk(1, 0, 1, 32'h0900_0000, NON, 5'h1F, 5'h00, 0, 1, DF, 5'b00000, 0);
        vt[22] = mk(1, 0, 1, 32'h0300_0000, NON, 5'h1F, 5'h00, 1, 1, DF, 5'b01000, 0);
        vt[23] = mk(1, 0, 0, 32'h0, IDL, 5'h1F, 5'h00, 1, 0, D3, 5'b00000, 0);
        vt[24] = mk(1, 0, 1, 32'h0A00_0000, NON, 5'h1F, 5'h00, 1, 0, DF, 5'b00000, 0);
        vt[25] = mk(1, 1, 0, 32'h0, IDL, 5'h1F, 5'h00, 0, 1, DF, 5'b00000, 0);
        vt[26] = mk(1, 0, 0, 32'h0, IDL, 5'h1F, 5'h00, 1, 0, DF, 5'b00000, 0);

        for (int i = 0; i < 27; i++) begin
            drive(vt[i].rst, vt[i].sel, vt[i].addr, vt[i].trans, vt[i].rdy, vt[i].resp);
            if (vt[i].chk) begin
                cyc($sformatf("row%0d", i), vt[i].e_rdy, vt[i].e_resp, vt[i].e_data,
                    vt[i].e_ssel, vt[i].e_to);
            end else begin
                @(posedge HCLK);
                #1;
            end
        end

        // Slave 3 recovers after TIMEOUT-1 wait states: no forced error.
        drive(0, 1, 32'h0300_0000, NON, 5'b10111, 5'h00);
        cyc("near_acc", 1, 0, DF, 5'b01000, 0);
        for (int k = 1; k <= 7; k++) begin
            drive(0, 0, 32'h0, IDL, 5'b10111, 5'h00);
            cyc($sformatf("near_wait%0d", k), 0, 0, D3, 5'b00000, 0);
        end
        drive(0, 0, 32'h0, IDL, 5'h1F, 5'h00);
        cyc("near_done", 1, 0, D3, 5'b00000, 0);
        cyc("near_idle", 1, 0, DF, 5'b00000, 0);

        // Slave 3 hangs: 8 waits, then ERR1 (with pulse) and ERR2.
        drive(0, 1, 32'h0300_0000, NON, 5'b10111, 5'h00);
        cyc("to_acc", 1, 0, DF, 5'b01000, 0);
        drive(0, 0, 32'h0, IDL, 5'b10111, 5'h00);
        for (int k = 1; k <= 8; k++) begin
            cyc($sformatf("to_wait%0d", k), 0, 0, D3, 5'b00000, 0);
        end
        cyc("to_err1", 0, 1, DF, 5'b00000, 1);
        cyc("to_err2", 1, 1, DF, 5'b00000, 0);
        // Slave 3 stays hung; a transfer to slot 0 must still complete.
        drive(0, 1, 32'h0000_0000, NON, 5'b10111, 5'h00);
        cyc("after_acc", 1, 0, DF, 5'b00001, 0);
        drive(0, 0, 32'h0, IDL, 5'b10111, 5'h00);
        cyc("after_data", 1, 0, D0, 5'b00000, 0);
        cyc("after_idle", 1, 0, DF, 5'b00000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahbl_splitter_n.md
# ahbl_splitter_n

Parametrised AHB-Lite data-phase splitter for the peripheral sub-bus. It decodes the HADDR[27:24] slot field into one of NS slave selects and registers the selection for the data phase. It muxes HRDATA/HREADY/HRESP back from the selected slave. It adds two things the fixed five-slave splitter lacks: a built-in default slave that returns a two-cycle AHB ERROR for unmapped slots, and a per-transfer watchdog that force-completes a hung slave with ERROR.

## Interface
Parameters:
- NS, 5, number of slaves (1..16)
- SLOT_IDS, {4'h4,4'h3,4'h2,4'h1,4'h0}, NS×4-bit packed slot IDs; slave i owns SLOT_IDS[4i+3:4i]
- TIMEOUT, 255, maximum wait-state cycles before forced error (0 disables watchdog, max 65535)
- RD_DEFAULT, 32'hBADDBEEF, HRDATA when no slave is in data phase

Ports:
- HCLK  in  1  bus clock; one clock, all state on rising edge
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  splitter selected by upstream decoder
- HADDR  in  32  address-phase address
- HTRANS  in  2  transfer type; bit 1 = NONSEQ/SEQ
- HREADY  out  1  bus ready, fed to master and all slaves
- HRESP  out  1  0 OKAY, 1 ERROR
- HRDATA  out  32  read data
- S_SEL  out  NS  one-hot address-phase slave select
- S_HRDATA  in  NS×32  slave read data, slave i at [32i+31:32i]
- S_HREADYOUT  in  NS  slave ready
- S_HRESP  in  NS  slave response
- TO_PULSE  out  1  one-cycle pulse when the watchdog fires

## Operation
- Decode (combinational): hit[i] = (HADDR[27:24] == SLOT_IDS[i]). When duplicates exist, the lowest index wins. S_SEL = HSEL ? onehot(hit) : 0. Unmapped means HSEL and no hit.
- Accept = HSEL & HTRANS[1] & HREADY. On accept, latch sel_d (index) and go to SLAVE, or to ERR1 if unmapped. Non-accepted cycles in which HREADY is high go to IDLE.
- State machine:
  - IDLE: HREADY=1, HRESP=0, HRDATA=RD_DEFAULT.
  - SLAVE: HREADY = S_HREADYOUT[sel_d] and HRESP = S_HRESP[sel_d], passed through combinationally; HRDATA = S_HRDATA[sel_d]. Exits when HREADY=1, to the next state per accept.
  - ERR1: HREADY=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADY=1, HRESP=1. Next state per accept (a master that ignores the error and pipelines a new transfer is honoured).
- Watchdog: wcnt clears on every accept. In SLAVE it increments each cycle S_HREADYOUT[sel_d]=0. When wcnt==TIMEOUT-1 and the slave is still low, go to ERR1 and pulse TO_PULSE. Forced ERR1/ERR2 output overrides the slave. The abandoned slave receives no further handling.
- Slave-driven ERROR (S_HRESP=1) passes through unchanged; the splitter does not count or modify it.
- wcnt width is 16 bits and saturates; it never wraps.

## Timing
- Reset values: state IDLE, sel_d 0, wcnt 0. Outputs: HREADY=1, HRESP=0, HRDATA=RD_DEFAULT, TO_PULSE=0. S_SEL follows HADDR/HSEL combinationally, also during reset.
- Reset asserted mid-transfer (any state): the next edge gives IDLE, and outputs return to reset values in that cycle.
- Mapped zero-wait slave: data phase completes in the cycle after accept, with no added latency.
- Unmapped: exactly 2 data-phase cycles (ERR1 then ERR2).
- Timeout: after TIMEOUT wait cycles, ERR1 and ERR2 follow, and TO_PULSE is high during the first ERR1 cycle. The total data phase is TIMEOUT+2 cycles.
- Back-to-back: an accept on the final data-phase cycle of any state starts the next data phase on the following cycle.
- HTRANS IDLE/BUSY with HSEL high: not accepted, and the state does not change the watchdog.

## Structure
- Shared package ahbl_pkg holds: HTRANS codes (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11), HRESP codes (OKAY=0, ERROR=1), the splitter state enum {IDLE, SLAVE, ERR1, ERR2}, and the RD_DEFAULT constant.
- One sub-module, ahbl_slot_decoder: combinational HADDR[27:24] → one-hot and index plus a hit flag, parametrised by NS and SLOT_IDS. It is reused by future bus matrices.

## Test plan
- Reset then idle: HRESET for 3 cycles with HTRANS=IDLE → HREADY=1, HRESP=0, HRDATA=32'hBADDBEEF, TO_PULSE=0.
- Mapped read, slot 2, slave 2 returns 32'h12345678 with HREADYOUT=1 → S_SEL=5'b00100 in the address phase; next cycle HRDATA=32'h12345678, HREADY=1, HRESP=0.
- Unmapped HADDR=32'h4F00_0000, NONSEQ → data phase: HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then IDLE.
- Hung slave, TIMEOUT=8: slave 3 holds HREADYOUT=0 → 8 wait cycles, TO_PULSE for one cycle, 2-cycle ERROR, then HREADY=1; a following transfer to slot 0 completes normally.
- Back-to-back: slot 1 then slot 4 transfers, with a wait state on slave 1 → HRDATA switches to slave 4 only after slave 1's HREADYOUT=1.
- Reset asserted during ERR1 → next cycle HREADY=1, HRESP=0, state IDLE.
